instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the byte increment between sequential fetches.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 imem_req  output  1  SHALL indicate a fetch request is outstanding.
REQ-006 imem_addr  output  32  SHALL carry the byte address of the requested instruction.
REQ-007 imem_rdata  input  32  SHALL carry fetched instruction data, qualified by imem_valid.
REQ-008 imem_valid  input  1  SHALL pulse once per request when imem_rdata is valid.
REQ-009 branch_taken  input  1  SHALL request a PC redirect this cycle.
REQ-010 branch_target  input  32  SHALL carry the redirect address, sampled with branch_taken.
REQ-011 stall  input  1  SHALL hold the current instruction in decode while high.
REQ-012 ir_valid  output  1  SHALL mark ir, imm16 and pc_out as valid for decode.
REQ-013 ir  output  32  SHALL carry the instruction register.
REQ-014 imm16  output  16  SHALL equal ir[15:0], the operand for the downstream 16-to-32 sign extender.
REQ-015 pc_out  output  32  SHALL carry the address that ir was fetched from.

Function
REQ-016 FSM SHALL have states IDLE, FETCH, DECODE.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, stable until imem_valid.
REQ-019 On imem_valid in FETCH with no squash pending: ir<=imem_rdata, pc_out<=pc, pc<=pc+PC_STEP (mod 2^32), go to DECODE; ir_valid SHALL be 1 the following cycle.
REQ-020 In DECODE, imem_req SHALL be 0; with stall=0 go to FETCH and drop ir_valid; with stall=1 stay, holding ir, imm16, pc_out.
REQ-021 branch_taken SHALL take priority over stall and imem_valid in every state: pc<=branch_target.
REQ-022 Branch in DECODE: ir_valid SHALL be 0 next cycle, go to FETCH at target.
REQ-023 Branch in FETCH without imem_valid: set squash flag, keep imem_addr stable; the next imem_valid SHALL be discarded (no IR load), squash cleared, new request issued at target next cycle.
REQ-024 Branch in FETCH coincident with imem_valid: response discarded, no squash set, request at target next cycle.
REQ-025 imem_valid outside FETCH SHALL be ignored.
REQ-026 pc wrap from 32'hFFFF_FFFC SHALL give 32'h0000_0000 without error.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, squash=0, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir=0, pc_out=0, counters=0.
REQ-028 Reset mid-request SHALL abandon the outstanding fetch; a late imem_valid in IDLE SHALL be ignored.

Configuration
REQ-029 Macro IFETCH_PERF_CNT_EN defined: SHALL add outputs fetch_cnt[31:0] (increments per IR load) and stall_cnt[31:0] (increments per DECODE cycle with stall=1), both wrapping; undefined: these ports and counters SHALL not exist.

Structure
REQ-030 Package minirisc_pkg SHALL hold RESET_PC default, PC_STEP default, the FSM state typedef, and the imm16 field bounds.
REQ-031 Sub-module pc_unit SHALL hold pc and squash registers with increment/redirect logic; FSM and IR stay in instr_fetch.

Verification
REQ-032 Reset release, memory returns 32'h2001_0005 one cycle after req -> imem_addr=0, ir=32'h2001_0005, imm16=16'h0005, pc_out=0, next addr=4.
REQ-033 stall=1 for 3 cycles in DECODE -> ir_valid stays 1, ir unchanged, imem_req=0 throughout.
REQ-034 branch_taken, target 32'h100, during FETCH before imem_valid -> returned word discarded, next imem_addr=32'h100, ir_valid never asserted for discarded word.
REQ-035 branch_taken and imem_valid same cycle -> no IR load, req at target next cycle.
REQ-036 PC at 32'hFFFF_FFFC, fetch completes -> next imem_addr=0.
REQ-037 rst_n=0 while imem_req=1 -> all outputs at reset values next cycle; with IFETCH_PERF_CNT_EN, counters 0.

Source files
------------

// File: rtl/minirisc_pkg.sv
// rtl/minirisc_pkg.sv - shared fetch defaults, FSM state type and imm16 field bounds
package minirisc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP_DEFAULT  = 4;

    // Immediate operand field inside the instruction word.
    localparam int IMM16_HI = 15;
    localparam int IMM16_LO = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter and squash flag with increment/redirect logic
// Ports: clk, rst_n (sync, active-low); redirect/target load a branch address;
// advance steps pc by PC_STEP; set_squash/clr_squash control the squash flag.
// pc/squash are the registered values, pc_d/squash_d the values they take next edge.
module pc_unit
    import minirisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        advance,
    input  logic        set_squash,
    input  logic        clr_squash,
    output logic [31:0] pc,
    output logic [31:0] pc_d,
    output logic        squash,
    output logic        squash_d
);

    always_comb begin
        pc_d = pc;
        if (redirect) begin
            pc_d = target;
        end else if (advance) begin
            // Wraps naturally modulo 2^32.
            pc_d = pc + 32'(PC_STEP);
        end

        squash_d = squash;
        if (set_squash) begin
            squash_d = 1'b1;
        end else if (clr_squash) begin
            squash_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            squash <= 1'b0;
        end else begin
            pc     <= pc_d;
            squash <= squash_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM driving imem and holding the IR for decode
// Ports: clk, rst_n (sync, active-low); imem_req/imem_addr request a word,
// imem_rdata/imem_valid return it; branch_taken/branch_target redirect the pc;
// stall holds decode; ir_valid/ir/imm16/pc_out present the instruction.
// Optional macro IFETCH_PERF_CNT_EN adds fetch_cnt and stall_cnt outputs.
module instr_fetch
    import minirisc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [15:0] imm16,
    output logic [31:0] pc_out
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_d;
    logic         squash;
    logic         squash_d;
    logic         in_fetch;
    logic         load_ir;
    logic         set_squash;
    logic         clr_squash;

    assign in_fetch   = (state == FETCH);
    // A response is only accepted when no redirect arrives with it and it
    // does not belong to a request abandoned by an earlier branch.
    assign load_ir    = in_fetch && imem_valid && !branch_taken && !squash;
    assign set_squash = in_fetch && branch_taken && !imem_valid;
    assign clr_squash = in_fetch && imem_valid;

    pc_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .redirect   (branch_taken),
        .target     (branch_target),
        .advance    (load_ir),
        .set_squash (set_squash),
        .clr_squash (clr_squash),
        .pc         (pc),
        .pc_d       (pc_d),
        .squash     (squash),
        .squash_d   (squash_d)
    );

    assign imm16 = ir[IMM16_HI:IMM16_LO];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            ir_valid  <= 1'b0;
            ir        <= 32'h0;
            pc_out    <= 32'h0;
        end else begin
            // While a squashed request is still in flight the address must
            // stay on the abandoned word; otherwise it tracks the next pc.
            if (!squash_d) begin
                imem_addr <= pc_d;
            end
            if (load_ir) begin
                ir     <= imem_rdata;
                pc_out <= pc;
            end
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (load_ir) begin
                        state    <= DECODE;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end
                end
                DECODE: begin
                    if (branch_taken || !stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        ir_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (load_ir) begin
                fetch_cnt <= fetch_cnt + 32'h1;
            end
            if ((state == DECODE) && stall) begin
                stall_cnt <= stall_cnt + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        stall = 1'b0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] imm16;
    logic [31:0] pc_out;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .ir_valid      (ir_valid),
        .ir            (ir),
        .imm16         (imm16),
        .pc_out        (pc_out)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether a request is outstanding, whether an
    // instruction is held for decode, and whether the next response is stale.
    logic        started = 1'b0;
    logic        m_first;
    logic        m_req;
    logic        m_have;
    logic        m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_ir;
    logic [31:0] m_pcout;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    always @(posedge clk) begin
        if (!rst_n) begin
            started   = 1'b1;
            m_first   = 1'b1;
            m_req     = 1'b0;
            m_have    = 1'b0;
            m_drop    = 1'b0;
            m_pc      = 32'h0;
            m_addr    = 32'h0;
            m_ir      = 32'h0;
            m_pcout   = 32'h0;
            m_fetches = 32'h0;
            m_stalls  = 32'h0;
        end else if (started) begin
            if (m_have && stall) m_stalls = m_stalls + 1;
            if (branch_taken) begin
                if (m_req && !imem_valid) begin
                    m_drop = 1'b1;
                end else begin
                    m_drop = 1'b0;
                    m_addr = branch_target;
                end
                m_pc    = branch_target;
                m_req   = 1'b1;
                m_have  = 1'b0;
                m_first = 1'b0;
            end else if (m_first) begin
                m_first = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end else if (m_req) begin
                if (imem_valid && m_drop) begin
                    m_drop = 1'b0;
                    m_addr = m_pc;
                end else if (imem_valid) begin
                    m_ir      = imem_rdata;
                    m_pcout   = m_pc;
                    m_pc      = m_pc + STEP;
                    m_addr    = m_pc;
                    m_req     = 1'b0;
                    m_have    = 1'b1;
                    m_fetches = m_fetches + 1;
                end
            end else if (m_have && !stall) begin
                m_have = 1'b0;
                m_req  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
            chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_have});
            if (m_req || m_first) chk("imem_addr", imem_addr, m_addr);
            if (m_have || m_first) begin
                chk("ir", ir, m_ir);
                chk("imm16", {16'h0, imm16}, {16'h0, m_ir[15:0]});
                chk("pc_out", pc_out, m_pcout);
            end
`ifdef IFETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, m_fetches);
            chk("stall_cnt", stall_cnt, m_stalls);
`endif
        end
    end

    // Inputs change at a negedge, are sampled at the next posedge, and the
    // task returns at the following negedge where outputs are settled.
    task automatic drive(input logic rs, input logic v, input logic [31:0] d,
                         input logic b, input logic [31:0] t, input logic s);
        rst_n         = rs;
        imem_valid    = v;
        imem_rdata    = d;
        branch_taken  = b;
        branch_target = t;
        stall         = s;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_irv", {31'h0, ir_valid}, 32'h0);
        chk("rst_ir", ir, 32'h0);

        drive(1, 0, 0, 0, 0, 0);
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        drive(1, 1, 32'h2001_0005, 0, 0, 0);
        chk("load_ir", ir, 32'h2001_0005);
        chk("load_imm", {16'h0, imm16}, 32'h0005);
        chk("load_pc", pc_out, 32'h0);
        chk("load_irv", {31'h0, ir_valid}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 1);
            chk("stall_irv", {31'h0, ir_valid}, 32'h1);
            chk("stall_ir", ir, 32'h2001_0005);
            chk("stall_req", {31'h0, imem_req}, 32'h0);
        end

        drive(1, 0, 0, 0, 0, 0);
        chk("next_addr", imem_addr, 32'h4);
        chk("next_req", {31'h0, imem_req}, 32'h1);

        drive(1, 0, 0, 1, 32'h100, 0);
        chk("squash_hold", imem_addr, 32'h4);
        drive(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("squash_addr", imem_addr, 32'h100);
        chk("squash_irv", {31'h0, ir_valid}, 32'h0);
        drive(1, 1, 32'h1111_2222, 0, 0, 0);
        chk("tgt_pc", pc_out, 32'h100);
        chk("tgt_ir", ir, 32'h1111_2222);

        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h3333_3333, 1, 32'h200, 0);
        chk("coinc_irv", {31'h0, ir_valid}, 32'h0);
        chk("coinc_addr", imem_addr, 32'h200);
        chk("coinc_req", {31'h0, imem_req}, 32'h1);
        drive(1, 1, 32'h4444_0007, 0, 0, 0);
        chk("coinc_load", pc_out, 32'h200);

        drive(1, 0, 0, 1, 32'hFFFF_FFFC, 1);
        chk("dec_br_irv", {31'h0, ir_valid}, 32'h0);
        chk("dec_br_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1, 1, 32'h5555_8001, 0, 0, 0);
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_imm", {16'h0, imm16}, 32'h8001);
        drive(1, 1, 32'h6666_6666, 0, 0, 1);
        chk("ignore_dec", ir, 32'h5555_8001);
        drive(1, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("cnt_fetch", fetch_cnt, 32'd4);
        chk("cnt_stall", stall_cnt, 32'd5);
`endif

        drive(0, 0, 0, 0, 0, 0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_irv", {31'h0, ir_valid}, 32'h0);
        chk("mid_rst_ir", ir, 32'h0);
        chk("mid_rst_pc", pc_out, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("mid_rst_fc", fetch_cnt, 32'h0);
        chk("mid_rst_sc", stall_cnt, 32'h0);
`endif
        drive(1, 1, 32'h7777_7777, 0, 0, 0);
        chk("late_irv", {31'h0, ir_valid}, 32'h0);
        chk("late_addr", imem_addr, 32'h0);
        drive(1, 1, 32'h8888_0042, 0, 0, 0);
        chk("after_rst_ir", ir, 32'h8888_0042);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
